// File: rtl/sdram_arb_ctrl.sv
// sdram_arb_ctrl: fetch/data arbiter and fixed 8-cycle SDRAM command sequencer.
// Define SDRAM_ARB_DPRIO_EN for fixed data-port priority (default round-robin).
module sdram_arb_ctrl (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic [31:0] rdata,
    output logic [1:0]  rword,
    output logic        f_rvalid,
    output logic        d_rvalid,
    output logic        f_done,
    output logic        d_done,
    output logic [31:0] Addr,
    inout  wire  [31:0] Data,
    output logic        nRAS,
    output logic        nCAS,
    output logic        nWE,
    output logic        nCS,
    output logic        SEQ,
    output logic        BYTE
);

    typedef enum logic [2:0] {
        GUARD, IDLE, ACT, CAS, WAIT, DATA, PRE
    } state_t;

    state_t      state;
    state_t      nxt;
    logic        ph;
    logic [2:0]  gcnt;
    logic        wr_q;
    logic        port_d;
    logic [31:0] wdata_q;
    logic [2:0]  cap;
    logic        cap_d;
    logic        busy;
    logic        oe;
    logic        pick_f;
    logic        pick_d;

`ifdef SDRAM_ARB_DPRIO_EN
    always_comb begin
        pick_d = d_req;
        pick_f = f_req && !d_req;
    end
`else
    // last_d resets high so the first tie after reset goes to fetch
    logic last_d;

    always_comb begin
        pick_d = d_req && (!f_req || !last_d);
        pick_f = f_req && !pick_d;
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET)
            last_d <= 1'b1;
        else if (f_gnt || d_gnt)
            last_d <= d_gnt;
    end
`endif

    assign f_gnt = (state == IDLE) && pick_f;
    assign d_gnt = (state == IDLE) && pick_d;

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET)
            state <= GUARD;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            GUARD:   if (gcnt == 3'd7) nxt = IDLE;
            IDLE:    if (f_gnt || d_gnt) nxt = ACT;
            ACT:     if (ph) nxt = CAS;
            CAS:     if (ph) nxt = WAIT;
            WAIT:    nxt = DATA;
            DATA:    nxt = PRE;
            PRE:     nxt = IDLE;
            default: nxt = GUARD;
        endcase
    end

    // ACT and CAS each span two cycles; ph marks the second one
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            gcnt <= 3'd0;
            ph   <= 1'b0;
        end else begin
            if (state == GUARD)
                gcnt <= gcnt + 3'd1;
            ph <= (state == ACT || state == CAS) ? !ph : 1'b0;
        end
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            Addr    <= 32'd0;
            wr_q    <= 1'b0;
            BYTE    <= 1'b0;
            wdata_q <= 32'd0;
            port_d  <= 1'b0;
        end else if (f_gnt) begin
            Addr    <= f_addr;
            wr_q    <= 1'b0;
            BYTE    <= 1'b0;
            port_d  <= 1'b0;
        end else if (d_gnt) begin
            Addr    <= d_addr;
            wr_q    <= d_we;
            BYTE    <= d_we && d_byte;
            wdata_q <= d_wdata;
            port_d  <= 1'b1;
        end
    end

    assign busy = (state != GUARD) && (state != IDLE);
    assign oe   = wr_q && (state == CAS || state == WAIT || state == DATA);
    assign nRAS = !busy;
    assign nCS  = !busy;
    assign nWE  = !(busy && wr_q);
    // reads strobe CAS in the first CAS cycle, writes in the second
    assign nCAS = !(state == CAS && ph == wr_q);
    assign SEQ  = 1'b0;
    assign Data = oe ? (BYTE ? {4{wdata_q[7:0]}} : wdata_q) : 32'bz;

    // cap counts line-fill captures left; it runs past PRE into IDLE
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            cap      <= 3'd0;
            cap_d    <= 1'b0;
            rdata    <= 32'd0;
            rword    <= 2'd0;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_done   <= 1'b0;
            d_done   <= 1'b0;
        end else begin
            if (state == CAS && ph && !wr_q) begin
                cap   <= 3'd4;
                cap_d <= port_d;
            end else if (cap != 3'd0) begin
                cap <= cap - 3'd1;
            end
            if (cap != 3'd0) begin
                rdata <= Data;
                rword <= 2'(3'd4 - cap);
            end
            f_rvalid <= (cap != 3'd0) && !cap_d;
            d_rvalid <= (cap != 3'd0) && cap_d;
            f_done   <= (cap == 3'd1) && !cap_d;
            d_done   <= ((cap == 3'd1) && cap_d) || (state == DATA && wr_q);
        end
    end

endmodule

// File: tb/tb_sdram_arb_ctrl.sv
// tb_sdram_arb_ctrl: directed + random bench with SDRAM bus model and
// a word-array reference of memory contents and per-slot timing.
module tb_sdram_arb_ctrl;

    logic        MCLK;
    logic        nRESET;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        d_req;
    logic        d_we;
    logic        d_byte;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic [31:0] rdata;
    logic [1:0]  rword;
    logic        f_rvalid;
    logic        d_rvalid;
    logic        f_done;
    logic        d_done;
    logic [31:0] Addr;
    wire  [31:0] Data;
    logic        nRAS;
    logic        nCAS;
    logic        nWE;
    logic        nCS;
    logic        SEQ;
    logic        BYTE;

    sdram_arb_ctrl dut (
        .MCLK(MCLK), .nRESET(nRESET),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .rdata(rdata), .rword(rword),
        .f_rvalid(f_rvalid), .d_rvalid(d_rvalid),
        .f_done(f_done), .d_done(d_done),
        .Addr(Addr), .Data(Data),
        .nRAS(nRAS), .nCAS(nCAS), .nWE(nWE), .nCS(nCS),
        .SEQ(SEQ), .BYTE(BYTE)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    int errors = 0;
    int checks = 0;
    int f_done_cnt = 0;
    int d_done_cnt = 0;
    int conflicts = 0;
    int cyc = 0;

    // memory device (bus side) and reference contents (spec side)
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        mdrv = 1'b0;
    logic [31:0] mdata = 32'd0;
    logic        ras_prev = 1'b1;
    logic [31:0] row = 32'd0;
    logic [2:0]  rd_t = 3'd0;
    logic [2:0]  rk;
    logic [1:0]  lane;

    assign Data = mdrv ? mdata : 32'bz;
    assign rk   = rd_t - 3'd1;
    assign lane = row[1:0];

    always @(posedge MCLK) begin
        cyc++;
        ras_prev <= nRAS;
        if (!nRAS && ras_prev)
            row <= Addr;
        if (!nCAS && !nWE) begin
            if (BYTE)
                mem[row[11:2]][8*lane +: 8] <= Data[8*lane +: 8];
            else
                mem[row[11:2]] <= Data;
        end
        if (!nCAS && nWE) begin
            rd_t <= 3'd1;
        end else if (rd_t == 3'd5) begin
            mdrv <= 1'b0;
            rd_t <= 3'd0;
        end else if (rd_t != 3'd0) begin
            mdrv  <= 1'b1;
            mdata <= mem[{row[11:4], rk[1:0]}];
            rd_t  <= rd_t + 3'd1;
        end
    end

    always @(negedge MCLK) begin
        if (f_done) f_done_cnt++;
        if (d_done) d_done_cnt++;
        if (mdrv && (Data !== mdata)) conflicts++;
    end

    logic [31:0] rd_words [0:3];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge MCLK);
        #1;
    endtask

    task automatic ref_write(input bit byt, input logic [31:0] a,
                             input logic [31:0] wd);
        logic [9:0] i;
        i = a[11:2];
        if (byt)
            ref_mem[i][8*a[1:0] +: 8] = wd[7:0];
        else
            ref_mem[i] = wd;
    endtask

    task automatic run_txn(input bit isd, input bit we, input bit byt,
                           input logic [31:0] a, input logic [31:0] wd);
        int n;
        int cas_j;
        logic [31:0] wbus;
        logic [9:0] base;
        logic pg;
        @(negedge MCLK);
        if (isd) begin
            d_req = 1'b1; d_we = we; d_byte = byt;
            d_addr = a; d_wdata = wd;
        end else begin
            f_req = 1'b1; f_addr = a;
        end
        #1;
        n = 0;
        while (!(isd ? d_gnt : f_gnt) && n < 40) begin
            tick();
            n++;
        end
        pg = isd ? d_gnt : f_gnt;
        chk("gnt", {31'd0, pg}, 32'd1);
        if (!pg) begin
            f_req = 1'b0; d_req = 1'b0;
            return;
        end
        chk("gnt_excl", {31'd0, isd ? f_gnt : d_gnt}, 32'd0);
        @(posedge MCLK);
        #1;
        f_req = 1'b0; d_req = 1'b0;
        wbus  = byt ? {4{wd[7:0]}} : wd;
        base  = {a[11:4], 2'b00};
        cas_j = we ? 3 : 2;
        if (we) ref_write(byt, a, wd);
        for (int j = 0; j <= 8; j++) begin
            tick();
            if (j == 0) begin
                chk("nras_g", {31'd0, nRAS}, 32'd0);
                chk("nwe_g", {31'd0, nWE}, {31'd0, !we});
                chk("addr", Addr, a);
            end
            chk($sformatf("ncas_j%0d", j), {31'd0, nCAS},
                {31'd0, j != cas_j});
            if (we) begin
                chk($sformatf("ddone_j%0d", j), {31'd0, d_done},
                    {31'd0, j == 6});
                if (j >= 2 && j <= 5)
                    chk($sformatf("data_j%0d", j), Data, wbus);
                else if (j <= 6)
                    chk($sformatf("data_off_j%0d", j),
                        {31'd0, Data !== wbus}, 32'd1);
            end else begin
                chk($sformatf("rvalid_j%0d", j),
                    {30'd0, isd ? d_rvalid : f_rvalid,
                     isd ? f_rvalid : d_rvalid},
                    {30'd0, j >= 5, 1'b0});
                chk($sformatf("done_j%0d", j),
                    {30'd0, isd ? d_done : f_done,
                     isd ? f_done : d_done},
                    {30'd0, j == 8, 1'b0});
                if (j >= 5) begin
                    chk("rword", {30'd0, rword}, j - 5);
                    chk("rdata", rdata, ref_mem[base + 10'(j - 5)]);
                    rd_words[j-5] = rdata;
                end
            end
        end
    endtask

    initial begin
        int n;
        int prev_cyc;
        int fd0;
        int dd0;
        bit last_d;
        bit exp_d;
        bit got_d;
        bit isd;
        bit we;
        bit byt;
        logic [31:0] wd;
        nRESET = 1'b1;
        f_req = 1'b0; f_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int k = 0; k < 4; k++) begin
            mem[64+k] = 32'hA000_00A0 + k;
            ref_mem[64+k] = mem[64+k];
        end

        #2 nRESET = 1'b0;
        #1;
        chk("rst_ctl",
            {20'd0, nRAS, nCAS, nWE, nCS, BYTE, SEQ, f_gnt, d_gnt,
             f_rvalid, d_rvalid, f_done, d_done},
            32'h0000_0F00);
        chk("rst_addr", Addr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rword", {30'd0, rword}, 32'd0);
        repeat (2) @(negedge MCLK);
        nRESET = 1'b1;

        // both ports held: reads on fetch, writes on data
        last_d = 1'b1;
        f_addr = 32'h300;
        d_addr = 32'h340; d_we = 1'b1; d_byte = 1'b0;
        d_wdata = $urandom | 32'd1;
        f_req = 1'b1; d_req = 1'b1;
        #1;
        prev_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(f_gnt || d_gnt) && n < 40) begin
                tick();
                n++;
            end
            chk("arb_gnt", {31'd0, f_gnt || d_gnt}, 32'd1);
            chk("arb_excl", {31'd0, f_gnt && d_gnt}, 32'd0);
`ifdef SDRAM_ARB_DPRIO_EN
            exp_d = 1'b1;
`else
            exp_d = !last_d;
`endif
            got_d = d_gnt;
            chk($sformatf("arb_port%0d", k), {31'd0, got_d},
                {31'd0, exp_d});
            if (k > 0)
                chk("arb_space", cyc - prev_cyc, 32'd8);
            prev_cyc = cyc;
            last_d = got_d;
            if (got_d) ref_write(1'b0, d_addr, d_wdata);
            @(posedge MCLK);
            #1;
            if (k == 3) begin
                f_req = 1'b0; d_req = 1'b0;
            end else if (got_d) begin
                d_wdata = $urandom | 32'd1;
            end
        end
        repeat (12) tick();

        // directed transactions
        run_txn(1'b0, 1'b0, 1'b0, 32'h104, 32'd0);
        chk("fetch_w0", rd_words[0], 32'hA000_00A0);
        chk("fetch_w3", rd_words[3], 32'hA000_00A3);
        run_txn(1'b1, 1'b1, 1'b0, 32'h200, 32'hDEADBEEF);
        run_txn(1'b1, 1'b0, 1'b0, 32'h200, 32'd0);
        chk("rd_deadbeef", rd_words[0], 32'hDEADBEEF);
        run_txn(1'b1, 1'b1, 1'b0, 32'h200, 32'h11223344);
        run_txn(1'b1, 1'b1, 1'b1, 32'h202, 32'h0000005A);
        run_txn(1'b0, 1'b0, 1'b0, 32'h208, 32'd0);
        chk("rd_byte", rd_words[0], 32'h115A3344);

        // random mix, full 32-bit addresses wrap onto the array
        for (int t = 0; t < 24; t++) begin
            isd = 1'($urandom_range(0, 1));
            we  = isd ? 1'($urandom_range(0, 1)) : 1'b0;
            byt = 1'($urandom_range(0, 1));
            wd  = $urandom | 32'd1;
            run_txn(isd, we, byt, $urandom, wd);
        end

        // reset pulse during a read, three edges after S
        @(negedge MCLK);
        f_addr = 32'h180; f_req = 1'b1;
        #1;
        n = 0;
        while (!f_gnt && n < 40) begin
            tick();
            n++;
        end
        chk("rst_pre_gnt", {31'd0, f_gnt}, 32'd1);
        @(posedge MCLK);
        #1 f_req = 1'b0;
        repeat (4) @(posedge MCLK);
        #2 nRESET = 1'b0;
        fd0 = f_done_cnt;
        dd0 = d_done_cnt;
        #1;
        chk("rst_mid_ctl",
            {20'd0, nRAS, nCAS, nWE, nCS, BYTE, SEQ, f_gnt, d_gnt,
             f_rvalid, d_rvalid, f_done, d_done},
            32'h0000_0F00);
        chk("rst_mid_addr", Addr, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        @(negedge MCLK);
        nRESET = 1'b1;
        f_req = 1'b1;
        n = 0;
        do begin
            @(posedge MCLK);
            n++;
            #1;
        end while (!f_gnt && n < 40);
        chk("rst_gnt_seen", {31'd0, f_gnt}, 32'd1);
        chk("rst_gnt_delay", {31'd0, (n + 1) >= 9}, 32'd1);
        @(posedge MCLK);
        #1 f_req = 1'b0;
        repeat (12) tick();
        chk("rst_fdone", f_done_cnt - fd0, 32'd1);
        chk("rst_ddone", d_done_cnt - dd0, 32'd0);

        chk("bus_contention", conflicts, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
